// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction reads and fills the
// IF/ID pipeline register. A one-entry skid buffer catches an instruction that
// returns while decode is stalled, so it is not lost.
//
// Handshake: an instruction is taken from memory when iREN=1 and ihit=1 at a
// rising edge. It moves into IF/ID only when stall=0. With stall=1 it parks in
// the skid buffer and iREN drops until decode accepts it. flush wins over all
// other inputs and discards any ihit in the same cycle.
module fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_id,
    output logic [31:0] npc_id,
    output logic        valid_id,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] skid_instr;
    logic [31:0] skid_npc;
    logic        skid_valid;

    // Modulo-2^32 increment; wraps naturally at the top of the address space.
    assign pc_plus4 = pc + 32'd4;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: flush overrides everything, halt word freezes fetch.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        if (stall) begin
                            state_nxt = HOLD;
                        end else if (iload == HALT_WORD) begin
                            state_nxt = HALTED;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_nxt = (skid_instr == HALT_WORD) ? HALTED : FETCH;
                    end
                end
                HALTED: state_nxt = HALTED;
                default: state_nxt = FETCH;
            endcase
        end
    end

    // Output logic: read request depends on state only, address is the PC.
    always_comb begin
        iREN      = (state == FETCH);
        imemaddr  = pc;
        fsm_state = state;
    end

    // PC, IF/ID and skid buffer updates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc         <= PC_INIT;
            instr_id   <= 32'h0;
            npc_id     <= 32'h0;
            valid_id   <= 1'b0;
            skid_instr <= 32'h0;
            skid_npc   <= 32'h0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            // Word-align the target; the younger fetch becomes a bubble.
            pc         <= redirect_pc & ~32'd3;
            instr_id   <= 32'h0;
            npc_id     <= 32'h0;
            valid_id   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        if (ihit) begin
                            instr_id <= iload;
                            npc_id   <= pc_plus4;
                            valid_id <= 1'b1;
                            // PC stays on the halt word so it is not fetched past.
                            if (iload != HALT_WORD) begin
                                pc <= pc_plus4;
                            end
                        end else begin
                            instr_id <= 32'h0;
                            npc_id   <= 32'h0;
                            valid_id <= 1'b0;
                        end
                    end else if (ihit) begin
                        skid_instr <= iload;
                        skid_npc   <= pc_plus4;
                        skid_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_id   <= skid_instr;
                        npc_id     <= skid_npc;
                        valid_id   <= skid_valid;
                        skid_valid <= 1'b0;
                        if (skid_instr != HALT_WORD) begin
                            pc <= skid_npc;
                        end
                    end
                end
                default: begin
                    // HALTED: everything frozen until flush or reset.
                end
            endcase
        end
    end

endmodule
